// File: rtl/dpc_bp_collector.sv
// -----------------------------------------------------------------------------
// dpc_bp_collector
//
// Purpose:
//   Collects bad-point reports (x, y, type) from the k-value bad-pixel detector
//   into a ping-pong table with one bank per frame. At frame end the finished
//   bank is committed for host readout. The host reads it by address while the
//   next frame fills the other bank.
//
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   enable              allows a new frame to start collection
//   frame_start         single-cycle start-of-frame pulse
//   frame_done          single-cycle end-of-frame-detection pulse
//   bp_valid/bp_ready   bad-point report handshake
//   bp_x, bp_y, bp_type bad-point column, row and type (0 dead, 1 stuck)
//   host_lock           host is reading; a commit under lock is dropped
//   rd_addr, rd_data    host read port into the committed bank (1-cycle latency)
//                       rd_data = {type[31], y[30:16], x[15:0]}
//   result_valid        one-cycle pulse in the commit cycle
//   result_count        entries in the committed bank
//   result_overflow     committed frame had more reports than AUTO_BP_NUM
//   result_frame_id     frame counter value of the committed frame
//   dropped_frames      saturating count of frames that were not committed
//   collecting          high while a frame is being collected
// -----------------------------------------------------------------------------
module dpc_bp_collector #(
   parameter int CNT_WIDTH   = 10,
   parameter int AUTO_BP_NUM = 256,
   parameter int AUTO_BP_BIT = 8
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   enable,
   input  logic                   frame_start,
   input  logic                   frame_done,
   input  logic                   bp_valid,
   output logic                   bp_ready,
   input  logic [CNT_WIDTH-1:0]   bp_x,
   input  logic [CNT_WIDTH-1:0]   bp_y,
   input  logic                   bp_type,
   input  logic                   host_lock,
   input  logic [AUTO_BP_BIT-1:0] rd_addr,
   output logic [31:0]            rd_data,
   output logic                   result_valid,
   output logic [AUTO_BP_BIT:0]   result_count,
   output logic                   result_overflow,
   output logic [15:0]            result_frame_id,
   output logic [7:0]             dropped_frames,
   output logic                   collecting
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_COMMIT  = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic                   r_wr_bank;
   logic [AUTO_BP_BIT:0]   r_wr_cnt;
   logic                   r_ovf;
   logic                   r_last_vld;
   logic [CNT_WIDTH-1:0]   r_last_x;
   logic [CNT_WIDTH-1:0]   r_last_y;
   logic [15:0]            r_frame_cnt;
   logic [AUTO_BP_BIT:0]   r_result_count;
   logic                   r_result_ovf;
   logic [15:0]            r_result_fid;
   logic [7:0]             r_dropped;
   logic [31:0]            r_rd_data;
   logic [31:0]            r_mem [0:2*AUTO_BP_NUM-1];

   logic                   w_start;
   logic                   w_abort;
   logic                   w_accept;
   logic                   w_commit;
   logic                   w_lock_drop;
   logic                   w_dup;
   logic                   w_has_room;
   logic                   w_wr_en;
   logic [31:0]            w_wr_data;

   // A repeat of the previous accepted coordinate is the detector reporting the
   // same pixel twice; only the first occurrence is stored.
   assign w_dup      = r_last_vld && (bp_x == r_last_x) && (bp_y == r_last_y);
   // Bank size is a power of two, so the counter MSB flags a full bank.
   assign w_has_room = ~r_wr_cnt[AUTO_BP_BIT];
   assign w_wr_en    = w_accept && !w_dup && w_has_room;
   assign w_wr_data  = {bp_type, 15'(bp_y), 16'(bp_x)};

   always_comb begin
      w_state_nxt  = r_state;
      w_start      = 1'b0;
      w_abort      = 1'b0;
      w_accept     = 1'b0;
      w_commit     = 1'b0;
      w_lock_drop  = 1'b0;
      bp_ready     = 1'b0;
      collecting   = 1'b0;
      result_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (frame_start && enable) begin
               w_start     = 1'b1;
               w_state_nxt = S_COLLECT;
            end
         end
         S_COLLECT: begin
            bp_ready   = 1'b1;
            collecting = 1'b1;
            if (frame_done) begin
               // A report arriving with frame_done still belongs to this frame.
               w_accept    = bp_valid;
               w_state_nxt = S_COMMIT;
            end else if (frame_start) begin
               // Missing frame_done: abandon this frame, any same-cycle report
               // goes with it, and restart collection for the new frame.
               w_start = 1'b1;
               w_abort = 1'b1;
            end else begin
               w_accept = bp_valid;
            end
         end
         S_COMMIT: begin
            if (!host_lock) begin
               w_commit     = 1'b1;
               result_valid = 1'b1;
            end else begin
               w_lock_drop = 1'b1;
            end
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state        <= S_IDLE;
         r_wr_bank      <= 1'b0;
         r_wr_cnt       <= '0;
         r_ovf          <= 1'b0;
         r_last_vld     <= 1'b0;
         r_frame_cnt    <= '0;
         r_result_count <= '0;
         r_result_ovf   <= 1'b0;
         r_result_fid   <= '0;
         r_dropped      <= '0;
         r_rd_data      <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_start) begin
            r_wr_cnt    <= '0;
            r_ovf       <= 1'b0;
            r_last_vld  <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end else if (w_accept && !w_dup) begin
            r_last_vld <= 1'b1;
            if (w_has_room) begin
               r_wr_cnt <= r_wr_cnt + 1'b1;
            end else begin
               r_ovf <= 1'b1;
            end
         end

         if (w_commit) begin
            r_wr_bank      <= ~r_wr_bank;
            r_result_count <= r_wr_cnt;
            r_result_ovf   <= r_ovf;
            r_result_fid   <= r_frame_cnt;
         end

         if ((w_abort || w_lock_drop) && (r_dropped != 8'hFF)) begin
            r_dropped <= r_dropped + 8'd1;
         end

         // The read bank is the one not being written; it only moves on an
         // unlocked commit, so reads under host_lock stay stable.
         r_rd_data <= r_mem[{~r_wr_bank, rd_addr}];
      end
   end

   // Coordinate history and table storage carry no reset.
   always_ff @(posedge aclk) begin
      if (w_accept) begin
         r_last_x <= bp_x;
         r_last_y <= bp_y;
      end
      if (w_wr_en) begin
         r_mem[{r_wr_bank, r_wr_cnt[AUTO_BP_BIT-1:0]}] <= w_wr_data;
      end
   end

   assign rd_data         = r_rd_data;
   assign result_count    = r_result_count;
   assign result_overflow = r_result_ovf;
   assign result_frame_id = r_result_fid;
   assign dropped_frames  = r_dropped;

endmodule

// File: tb/tb_dpc_bp_collector.sv
module tb_dpc_bp_collector;

   localparam int CW  = 10;
   localparam int NUM = 256;
   localparam int BIT = 8;

   logic            aclk = 1'b0;
   logic            areset;
   logic            enable;
   logic            frame_start;
   logic            frame_done;
   logic            bp_valid;
   logic            bp_ready;
   logic [CW-1:0]   bp_x;
   logic [CW-1:0]   bp_y;
   logic            bp_type;
   logic            host_lock;
   logic [BIT-1:0]  rd_addr;
   logic [31:0]     rd_data;
   logic            result_valid;
   logic [BIT:0]    result_count;
   logic            result_overflow;
   logic [15:0]     result_frame_id;
   logic [7:0]      dropped_frames;
   logic            collecting;

   dpc_bp_collector #(.CNT_WIDTH(CW), .AUTO_BP_NUM(NUM), .AUTO_BP_BIT(BIT)) dut (
      .aclk(aclk), .areset(areset), .enable(enable),
      .frame_start(frame_start), .frame_done(frame_done),
      .bp_valid(bp_valid), .bp_ready(bp_ready),
      .bp_x(bp_x), .bp_y(bp_y), .bp_type(bp_type),
      .host_lock(host_lock), .rd_addr(rd_addr), .rd_data(rd_data),
      .result_valid(result_valid), .result_count(result_count),
      .result_overflow(result_overflow), .result_frame_id(result_frame_id),
      .dropped_frames(dropped_frames), .collecting(collecting)
   );

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a frame is a list of stored entries built from the
   // report rules; a commit snapshots that list for the host.
   bit          m_coll;
   logic [31:0] m_q[$];
   bit          m_ovf;
   bit          m_lv;
   int          m_lx, m_ly;
   int          m_fcnt;
   int          m_drop;
   logic [31:0] c_mem [NUM];
   int          c_count;
   bit          c_ovf;
   int          c_fid;

   // Last coordinates driven, used to create deliberate repeats.
   int          d_lx = 0, d_ly = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [31:0] pack(input int x, input int y, input bit t);
      logic [15:0] xx;
      logic [14:0] yy;
      xx = 16'(x);
      yy = 15'(y);
      return {t, yy, xx};
   endfunction

   task automatic m_reset();
      m_coll = 0; m_q.delete(); m_ovf = 0; m_lv = 0;
      m_fcnt = 0; m_drop = 0; c_count = 0; c_ovf = 0; c_fid = 0;
   endtask

   task automatic m_init();
      m_q.delete(); m_ovf = 0; m_lv = 0;
      m_fcnt = (m_fcnt + 1) % 65536;
   endtask

   task automatic m_accept(input int x, input int y, input bit t);
      if (m_lv && x == m_lx && y == m_ly) return;
      m_lv = 1; m_lx = x; m_ly = y;
      if (m_q.size() < NUM) m_q.push_back(pack(x, y, t));
      else m_ovf = 1;
   endtask

   task automatic drive_rep(input int x, input int y, input bit t);
      bp_valid = 1'b1; bp_x = CW'(x); bp_y = CW'(y); bp_type = t;
      d_lx = x; d_ly = y;
   endtask

   task automatic rand_rep(output int x, output int y, output bit t);
      if ($urandom_range(0, 3) == 0) begin
         x = d_lx; y = d_ly;
      end else begin
         x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
      end
      t = 1'($urandom_range(0, 1));
   endtask

   task automatic start_frame(input bit with_rep);
      int x, y; bit t;
      frame_start = 1'b1;
      if (with_rep) begin
         rand_rep(x, y, t);
         drive_rep(x, y, t);
      end
      tick();
      frame_start = 1'b0; bp_valid = 1'b0;
      if (m_coll) begin
         if (m_drop < 255) m_drop++;
         m_init();
      end else if (enable) begin
         m_init();
         m_coll = 1;
      end
      chk("collecting_after_start", collecting, m_coll);
      chk("bp_ready_after_start", bp_ready, m_coll);
      chk("dropped_after_start", dropped_frames, m_drop);
   endtask

   task automatic report(input int x, input int y, input bit t);
      drive_rep(x, y, t);
      tick();
      bp_valid = 1'b0;
      if (m_coll) m_accept(x, y, t);
   endtask

   task automatic rand_reports(input int n);
      int x, y; bit t;
      for (int i = 0; i < n; i++) begin
         rand_rep(x, y, t);
         report(x, y, t);
      end
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_count"}, result_count, c_count);
      chk({tag, "_ovf"}, result_overflow, c_ovf);
      chk({tag, "_fid"}, result_frame_id, c_fid);
      chk({tag, "_dropped"}, dropped_frames, m_drop);
   endtask

   task automatic end_frame(input bit lock, input bit with_rep, input bit fs_in_commit);
      int x, y; bit t;
      frame_done = 1'b1; host_lock = lock;
      if (with_rep) begin
         rand_rep(x, y, t);
         drive_rep(x, y, t);
      end
      tick();
      frame_done = 1'b0; bp_valid = 1'b0;
      if (with_rep) m_accept(x, y, t);
      frame_start = fs_in_commit;
      #1;
      chk("result_valid_in_commit", result_valid, !lock);
      chk("bp_ready_in_commit", bp_ready, 1'b0);
      tick();
      frame_start = 1'b0;
      if (!lock) begin
         for (int i = 0; i < m_q.size(); i++) c_mem[i] = m_q[i];
         c_count = m_q.size(); c_ovf = m_ovf; c_fid = m_fcnt;
      end else if (m_drop < 255) begin
         m_drop++;
      end
      m_coll = 0;
      chk("result_valid_after_commit", result_valid, 1'b0);
      chk("collecting_after_commit", collecting, 1'b0);
      check_status("commit");
      host_lock = 1'b0;
   endtask

   task automatic readback(input int n);
      for (int i = 0; i < n; i++) begin
         rd_addr = BIT'(i);
         tick();
         chk("rd_data", rd_data, c_mem[i]);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_bp_ready"}, bp_ready, 1'b0);
      chk({tag, "_collecting"}, collecting, 1'b0);
      chk({tag, "_result_valid"}, result_valid, 1'b0);
      chk({tag, "_count"}, result_count, 0);
      chk({tag, "_ovf"}, result_overflow, 1'b0);
      chk({tag, "_fid"}, result_frame_id, 0);
      chk({tag, "_dropped"}, dropped_frames, 0);
      chk({tag, "_rd_data"}, rd_data, 0);
   endtask

   logic [31:0] saved;

   initial begin
      areset = 1'b1; enable = 1'b1; frame_start = 1'b0; frame_done = 1'b0;
      bp_valid = 1'b0; bp_x = '0; bp_y = '0; bp_type = 1'b0;
      host_lock = 1'b0; rd_addr = '0;
      m_reset();
      repeat (3) tick();
      check_zero_outputs("reset");
      areset = 1'b0;
      tick();

      // Basic frame of three reports.
      start_frame(0);
      report(5, 7, 0); report(9, 7, 1); report(2, 8, 0);
      end_frame(0, 0, 0);
      chk("basic_fid_is_1", result_frame_id, 1);
      rd_addr = 8'd1;
      tick();
      chk("basic_entry1", rd_data, 32'h8007_0009);
      readback(3);

      // Overflow: 300 distinct reports.
      start_frame(0);
      for (int i = 0; i < 300; i++) report(i % 1024, 3 + i / 1024, 0);
      end_frame(0, 0, 0);
      chk("ovf_count_256", result_count, 256);
      chk("ovf_flag", result_overflow, 1'b1);
      rd_addr = 8'd255;
      tick();
      chk("ovf_entry255", rd_data, pack(255, 3, 0));
      readback(NUM);

      // Duplicate suppression.
      start_frame(0);
      report(4, 4, 0); report(4, 4, 1); report(6, 4, 0);
      end_frame(0, 0, 0);
      chk("dup_count_2", result_count, 2);
      readback(2);

      // Commit under host_lock is dropped; read bank stays put.
      start_frame(0);
      rand_reports(5);
      end_frame(0, 0, 0);
      rd_addr = 8'd0;
      tick();
      saved = rd_data;
      start_frame(0);
      rand_reports(7);
      end_frame(1, 0, 0);
      rd_addr = 8'd0;
      tick();
      chk("lock_rd_stable", rd_data, saved);
      start_frame(0);
      rand_reports(4);
      end_frame(0, 0, 0);
      readback(c_count);

      // Abort by repeated frame_start (with a lost report), report with
      // frame_done counted, frame_start during commit ignored.
      start_frame(0);
      rand_reports(6);
      start_frame(1);
      rand_reports(3);
      end_frame(0, 1, 1);
      readback(c_count);

      // enable gates only the start of a frame.
      enable = 1'b0;
      start_frame(0);
      enable = 1'b1;
      start_frame(0);
      enable = 1'b0;
      rand_reports(5);
      end_frame(0, 0, 0);
      enable = 1'b1;
      readback(c_count);

      // Randomised frames.
      for (int f = 0; f < 8; f++) begin
         start_frame(0);
         rand_reports($urandom_range(0, 30));
         if ($urandom_range(0, 3) == 0) begin
            start_frame($urandom_range(0, 1) == 1);
            rand_reports($urandom_range(0, 10));
         end
         end_frame($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 0);
         readback(c_count);
      end

      // Asynchronous reset in the middle of collection.
      start_frame(0);
      for (int i = 0; i < 10; i++) report(100 + i, 50, 1);
      @(posedge aclk);
      #2 areset = 1'b1;
      #1;
      m_reset();
      check_zero_outputs("async_reset");
      tick();
      areset = 1'b0;
      tick();
      start_frame(0);
      rand_reports(4);
      end_frame(0, 0, 0);
      chk("post_reset_fid", result_frame_id, 1);
      readback(c_count);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
